// File: rtl/period_meter.sv
// Measures high time, low time and period of a slow asynchronous square wave in clk cycles.
// Supports single-shot and continuous measurement, with a sticky timeout for missing or stuck input.
module period_meter #(
  parameter int unsigned     CW      = 25,
  parameter logic [CW-1:0]   TIMEOUT = CW'(1000000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig_in,
  input  logic          start,
  input  logic          cont,
  output logic          busy,
  output logic          valid,
  output logic          timeout,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] low_cnt,
  output logic [CW:0]   period
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, hist_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shadow_high_q, shadow_high_d;
  logic [CW-1:0] shadow_low_q, shadow_low_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [CW:0]   period_q, period_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic          rise_c, fall_c, edge_c, at_limit_c, expire_c;

  assign rise_c     = sync2_q & ~hist_q;
  assign fall_c     = ~sync2_q & hist_q;
  assign edge_c     = rise_c | fall_c;
  assign at_limit_c = (cnt_q == TIMEOUT);
  // A detected edge in the limit cycle wins over the timeout.
  assign expire_c   = at_limit_c & ~edge_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
      cnt_q         <= '0;
      shadow_high_q <= '0;
      shadow_low_q  <= '0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      period_q      <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sig_in;
      sync2_q       <= sync1_q;
      hist_q        <= sync2_q;
      cnt_q         <= cnt_d;
      shadow_high_q <= shadow_high_d;
      shadow_low_q  <= shadow_low_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      period_q      <= period_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Interval counter: restarts at 1 after every edge (and on an accepted start), saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_c || (state_q == S_IDLE && start)) begin
      cnt_d = CW'(1);
    end else if (cnt_q < TIMEOUT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    shadow_high_d = shadow_high_q;
    shadow_low_d  = shadow_low_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    timeout_d     = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ARM;
          timeout_d = 1'b0;
        end
      end
      S_ARM: begin
        if (rise_c) begin
          state_d = S_HIGH;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (fall_c) begin
          shadow_high_d = cnt_q;
          state_d       = S_LOW;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_LOW: begin
        if (rise_c) begin
          shadow_low_d = cnt_q;
          state_d      = S_DONE;
        end else if (expire_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        high_cnt_d = shadow_high_q;
        low_cnt_d  = shadow_low_q;
        period_d   = {1'b0, shadow_high_q} + {1'b0, shadow_low_q};
        valid_d    = 1'b1;
        if (cont) begin
          // A fall right after the terminating rise still belongs to the next high phase.
          if (fall_c) begin
            shadow_high_d = cnt_q;
            state_d       = S_LOW;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign high_cnt = high_cnt_q;
  assign low_cnt  = low_cnt_q;
  assign period   = period_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: single-shot, continuous, timeout, initial-high,
// mid-measurement reset and ignored start pulses.
module tb_period_meter;

  localparam int unsigned CW = 25;

  logic          clk;
  logic          rst;
  logic          sig_in;
  logic          start;
  logic          cont;
  logic          busy;
  logic          valid;
  logic          timeout;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] low_cnt;
  logic [CW:0]   period;

  period_meter #(
    .CW      (CW),
    .TIMEOUT (CW'(200))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .cont     (cont),
    .busy     (busy),
    .valid    (valid),
    .timeout  (timeout),
    .high_cnt (high_cnt),
    .low_cnt  (low_cnt),
    .period   (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passed;
  int cyc;
  int vcount;
  int last_vcyc;
  int v0;

  // Square-wave generator state, advanced once per step.
  logic gen_en;
  int   gen_hi;
  int   gen_lo;
  int   gen_ph;

  // Expected values for every valid pulse while chk_vals is set.
  logic chk_vals;
  logic chk_gap;
  int   exp_hi;
  int   exp_lo;
  int   exp_gap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      vcount++;
      if (chk_vals) begin
        chk("high_cnt", 64'(high_cnt), 64'(exp_hi));
        chk("low_cnt",  64'(low_cnt),  64'(exp_lo));
        chk("period",   64'(period),   64'(exp_hi + exp_lo));
      end
      if (chk_gap && last_vcyc >= 0) chk("valid_gap", 64'(cyc - last_vcyc), 64'(exp_gap));
      last_vcyc = cyc;
    end
    if (gen_en) begin
      gen_ph++;
      if (sig_in && gen_ph >= gen_hi) begin
        sig_in = 1'b0;
        gen_ph = 0;
      end else if (!sig_in && gen_ph >= gen_lo) begin
        sig_in = 1'b1;
        gen_ph = 0;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int base;
    base = vcount;
    for (int i = 0; i < budget && vcount == base; i++) step();
    chk(tag, 64'(vcount - base), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_valid"},    64'(valid),    64'd0);
    chk({tag, "_timeout"},  64'(timeout),  64'd0);
    chk({tag, "_high_cnt"}, 64'(high_cnt), 64'd0);
    chk({tag, "_low_cnt"},  64'(low_cnt),  64'd0);
    chk({tag, "_period"},   64'(period),   64'd0);
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    cyc       = 0;
    vcount    = 0;
    last_vcyc = -1;
    rst       = 1'b1;
    sig_in    = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    gen_en    = 1'b0;
    gen_hi    = 50;
    gen_lo    = 50;
    gen_ph    = 0;
    chk_vals  = 1'b0;
    chk_gap   = 1'b0;
    exp_hi    = 0;
    exp_lo    = 0;
    exp_gap   = 20;

    // Reset state.
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;

    // Single shot on a 50/50 wave.
    gen_en = 1'b1;
    repeat (5) step();
    exp_hi   = 50;
    exp_lo   = 50;
    chk_vals = 1'b1;
    v0 = vcount;
    pulse_start();
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    wait_valid("t1_valid", 400);
    repeat (150) step();
    chk("t1_one_valid", 64'(vcount - v0), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Continuous mode on a 7/13 wave, five results.
    gen_hi = 7;
    gen_lo = 13;
    repeat (60) step();
    exp_hi    = 7;
    exp_lo    = 13;
    chk_gap   = 1'b1;
    last_vcyc = -1;
    cont      = 1'b1;
    v0 = vcount;
    pulse_start();
    for (int i = 0; i < 500 && (vcount - v0) < 4; i++) step();
    cont = 1'b0;
    repeat (150) step();
    chk_gap = 1'b0;
    chk("t2_five_valid", 64'(vcount - v0), 64'd5);
    chk("t2_idle_busy", 64'(busy), 64'd0);

    // Stuck-low input times out after 200 cycles.
    gen_en   = 1'b0;
    sig_in   = 1'b0;
    chk_vals = 1'b0;
    repeat (20) step();
    v0 = vcount;
    pulse_start();
    repeat (199) step();
    chk("t3_pre_timeout", 64'(timeout), 64'd0);
    chk("t3_pre_busy",    64'(busy),    64'd1);
    step();
    chk("t3_timeout",     64'(timeout), 64'd1);
    chk("t3_busy",        64'(busy),    64'd0);
    chk("t3_no_valid",    64'(vcount - v0), 64'd0);
    chk("t3_hold_high",   64'(high_cnt), 64'd7);
    chk("t3_hold_period", 64'(period),   64'd20);
    pulse_start();
    chk("t3_timeout_clr", 64'(timeout), 64'd0);
    chk("t3_rearm_busy",  64'(busy),    64'd1);
    repeat (210) step();

    // Input already high at start, falls 10 cycles later, then 30/30.
    sig_in = 1'b1;
    repeat (20) step();
    exp_hi   = 30;
    exp_lo   = 30;
    chk_vals = 1'b1;
    pulse_start();
    repeat (9) step();
    sig_in = 1'b0;
    gen_ph = 0;
    gen_hi = 30;
    gen_lo = 30;
    gen_en = 1'b1;
    wait_valid("t4_valid", 300);
    chk("t4_timeout_clr", 64'(timeout), 64'd0);

    // Reset while in the high phase of a 50/50 measurement.
    gen_hi = 50;
    gen_lo = 50;
    repeat (120) step();
    exp_hi = 50;
    exp_lo = 50;
    v0 = vcount;
    pulse_start();
    for (int i = 0; i < 200 && sig_in; i++) step();
    for (int i = 0; i < 200 && !sig_in; i++) step();
    repeat (10) step();
    chk("t5_busy_high", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk_zero("t5_rst");
    rst = 1'b0;
    repeat (5) step();
    chk("t5_no_valid", 64'(vcount - v0), 64'd0);
    pulse_start();
    wait_valid("t5_valid", 400);

    // Start pulses while busy must not disturb an 11/17 measurement.
    gen_hi = 11;
    gen_lo = 17;
    repeat (60) step();
    exp_hi = 11;
    exp_lo = 17;
    v0 = vcount;
    pulse_start();
    for (int i = 0; i < 300 && vcount == v0; i++) begin
      if (busy && (i % 3 == 0)) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("t6_valid", 64'(vcount - v0), 64'd1);
    repeat (100) step();
    chk("t6_one_valid", 64'(vcount - v0), 64'd1);
    chk("t6_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
